// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the IFU/LSU data-memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // The watchdog counter only has to reach timeout-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and downstream-memory signals of the arbiter; slave = arbiter view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  ifu_rsp_valid;
    logic                  lsu_rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen,
               lsu_wdata, lsu_wmask, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
               rsp_rdata, rsp_err, mem_req_valid, mem_addr, mem_wen, mem_wdata,
               mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen,
               lsu_wdata, lsu_wmask, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
               rsp_rdata, rsp_err, mem_req_valid, mem_addr, mem_wen, mem_wdata,
               mem_wmask
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Combinational IFU/LSU grant. MEM_ARB_RR_EN selects round-robin on ties,
// otherwise the LSU always wins a tie.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_e last_owner,
    output logic   grant,
    output owner_e owner
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        grant = ifu_valid | lsu_valid;
        owner = OWN_LSU;
        if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
            owner = (last_owner == OWN_IFU) ? OWN_LSU : OWN_IFU;
`else
            owner = OWN_LSU;
`endif
        end else if (ifu_valid) begin
            owner = OWN_IFU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between IFU and LSU: IDLE->ISSUE->WAIT->RESP,
// one transaction outstanding, watchdog error response after TIMEOUT_CYCLES.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int               MASK_W     = DATA_W / 8;
    localparam int               CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic   grant;
    owner_e grant_owner;

    mem_arb_grant u_grant (
        .ifu_valid  (bus.ifu_req_valid),
        .lsu_valid  (bus.lsu_req_valid),
        .last_owner (last_owner_q),
        .grant      (grant),
        .owner      (grant_owner)
    );

    assign bus.ifu_req_ready = (state_q == IDLE) && grant && (grant_owner == OWN_IFU);
    assign bus.lsu_req_ready = (state_q == IDLE) && grant && (grant_owner == OWN_LSU);
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
    assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        mem_req_valid_d = mem_req_valid_q;
        ifu_rsp_valid_d = 1'b0;
        lsu_rsp_valid_d = 1'b0;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_err_d       = rsp_err_q;
        cnt_d           = cnt_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d         = grant_owner;
                    mem_req_valid_d = 1'b1;
                    state_d         = ISSUE;
                    if (grant_owner == OWN_LSU) begin
                        addr_d  = bus.lsu_addr;
                        wen_d   = bus.lsu_wen;
                        wdata_d = bus.lsu_wdata;
                        wmask_d = bus.lsu_wmask;
                    end else begin
                        addr_d  = bus.ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid || (TIMEOUT_EN && cnt_q == CNT_LAST)) begin
                    // Response wins over a timeout landing in the same cycle.
                    rsp_err_d       = !bus.mem_rsp_valid;
                    rsp_rdata_d     = (bus.mem_rsp_valid && !wen_q) ? bus.mem_rsp_rdata : '0;
                    ifu_rsp_valid_d = (owner_q == OWN_IFU);
                    lsu_rsp_valid_d = (owner_q == OWN_LSU);
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: synchronous reset is sampled inside the clocked block, and all
    // state updates are non-blocking so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= OWN_IFU;
            last_owner_q    <= OWN_IFU;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            mem_req_valid_q <= mem_req_valid_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
            cnt_q           <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT_CYCLES=16); honours MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int ifu_pulses = 0;
    int lsu_pulses = 0;

    always @(negedge clk) begin
        if (bus.ifu_rsp_valid === 1'b1) ifu_pulses++;
        if (bus.lsu_rsp_valid === 1'b1) lsu_pulses++;
    end

    typedef struct {
        logic        ifu_rdy, lsu_rdy;
        logic [31:0] addr, wdata;
        logic [3:0]  wmask;
        logic        wen;
        bit          issue_stable;
        logic        mem_valid_in_wait;
        int          wait_entry;
        int          lat;
        logic        ifu_rsp, lsu_rsp;
        logic [31:0] rdata;
        logic        err;
        bit          timed_out;
        logic        extra_pulse;
    } obs_t;

    task automatic clear_inputs();
        bus.ifu_req_valid = 1'b0; bus.ifu_addr  = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr  = '0;
        bus.lsu_wen       = 1'b0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
    endtask

    // Runs one request from IDLE; rsp_delay<0 means the memory never answers.
    task automatic run_txn(input bit lsu, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input int stall, input int rsp_delay,
                           input logic [31:0] rdata, output obs_t o);
        int cyc;
        bit got;
        o = '{default: 0};
        if (lsu) begin
            bus.lsu_req_valid = 1'b1; bus.lsu_addr = addr; bus.lsu_wen = wen;
            bus.lsu_wdata = wdata; bus.lsu_wmask = wmask;
        end else begin
            bus.ifu_req_valid = 1'b1; bus.ifu_addr = addr;
        end
        #1;
        o.ifu_rdy = bus.ifu_req_ready;
        o.lsu_rdy = bus.lsu_req_ready;
        @(negedge clk); cyc = 1;
        clear_inputs();
        o.addr = bus.mem_addr; o.wen = bus.mem_wen;
        o.wdata = bus.mem_wdata; o.wmask = bus.mem_wmask;
        o.issue_stable = (bus.mem_req_valid === 1'b1);
        repeat (stall) begin
            @(negedge clk); cyc++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== o.addr || bus.mem_wdata !== o.wdata ||
                bus.mem_wmask !== o.wmask || bus.mem_wen !== o.wen)
                o.issue_stable = 1'b0;
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk); cyc++;
        bus.mem_req_ready = 1'b0;
        o.wait_entry = cyc;
        o.mem_valid_in_wait = bus.mem_req_valid;
        if (rsp_delay >= 0) begin
            repeat (rsp_delay) begin @(negedge clk); cyc++; end
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = rdata;
            @(negedge clk); cyc++;
            bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
        end
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            if (bus.ifu_rsp_valid === 1'b1 || bus.lsu_rsp_valid === 1'b1) begin
                got = 1'b1; o.lat = cyc;
                o.ifu_rsp = bus.ifu_rsp_valid; o.lsu_rsp = bus.lsu_rsp_valid;
                o.rdata = bus.rsp_rdata; o.err = bus.rsp_err;
            end else begin
                @(negedge clk); cyc++;
            end
        end
        o.timed_out = !got;
        @(negedge clk);
        o.extra_pulse = bus.ifu_rsp_valid | bus.lsu_rsp_valid;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valids got=%b%b%b exp=000", bus.mem_req_valid, bus.ifu_rsp_valid, bus.lsu_rsp_valid); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wmask !== 4'h0 || bus.mem_wen !== 1'b0) begin
            failures++; $display("FAIL reset_fields got=%h/%h/%h/%b exp=0", bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen); end
        checks++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL reset_rsp got=%h/%b exp=0/0", bus.rsp_rdata, bus.rsp_err); end
        checks++; if (bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b%b exp=00", bus.ifu_req_ready, bus.lsu_req_ready); end
        @(negedge clk);
    endtask

    task automatic test_ifu_read();
        obs_t o;
        int lsu0 = lsu_pulses;
        run_txn(1'b0, 32'h8000_0000, 1'b0, '0, '0, 0, 0, 32'h0010_0073, o);
        checks++; if (o.ifu_rdy !== 1'b1 || o.lsu_rdy !== 1'b0) begin
            failures++; $display("FAIL ifu_ready got=%b%b exp=10", o.ifu_rdy, o.lsu_rdy); end
        checks++; if (o.addr !== 32'h8000_0000 || o.wen !== 1'b0 || o.wdata !== 32'h0 || o.wmask !== 4'h0) begin
            failures++; $display("FAIL ifu_fields got=%h/%b/%h/%h exp=80000000/0/0/0", o.addr, o.wen, o.wdata, o.wmask); end
        checks++; if (o.mem_valid_in_wait !== 1'b0) begin
            failures++; $display("FAIL ifu_req_drop got=%b exp=0", o.mem_valid_in_wait); end
        checks++; if (o.timed_out || o.lat != 3) begin
            failures++; $display("FAIL ifu_latency got=%0d exp=3", o.lat); end
        checks++; if (o.ifu_rsp !== 1'b1 || o.rdata !== 32'h0010_0073 || o.err !== 1'b0) begin
            failures++; $display("FAIL ifu_rsp got=%b/%h/%b exp=1/00100073/0", o.ifu_rsp, o.rdata, o.err); end
        checks++; if (o.extra_pulse !== 1'b0 || lsu_pulses != lsu0) begin
            failures++; $display("FAIL ifu_no_stray got=%b/%0d exp=0/0", o.extra_pulse, lsu_pulses - lsu0); end
    endtask

    task automatic test_lsu_write();
        obs_t o;
        run_txn(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, 0, 32'h1234_5678, o);
        checks++; if (o.lsu_rdy !== 1'b1 || o.ifu_rdy !== 1'b0) begin
            failures++; $display("FAIL lsu_ready got=%b%b exp=10", o.lsu_rdy, o.ifu_rdy); end
        checks++; if (o.addr !== 32'h8000_1000 || o.wen !== 1'b1 || o.wdata !== 32'hDEAD_BEEF || o.wmask !== 4'b0011) begin
            failures++; $display("FAIL lsu_fields got=%h/%b/%h/%h exp=80001000/1/deadbeef/3", o.addr, o.wen, o.wdata, o.wmask); end
        checks++; if (o.timed_out || o.lat != 3 || o.lsu_rsp !== 1'b1 || o.ifu_rsp !== 1'b0) begin
            failures++; $display("FAIL lsu_rsp got=lat%0d/%b%b exp=lat3/10", o.lat, o.lsu_rsp, o.ifu_rsp); end
        checks++; if (o.rdata !== 32'h0 || o.err !== 1'b0) begin
            failures++; $display("FAIL lsu_write_rdata got=%h/%b exp=0/0", o.rdata, o.err); end
    endtask

    task automatic test_arbitration();
        int got_owner [6];
        bit [5:0] exp_lsu;
        int irem = 3, lrem = 3;
        bit bad_ready = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_lsu = 6'b010101;
`else
        exp_lsu = 6'b000111;
`endif
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0100;
        bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_3000; bus.lsu_wen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            #1;
            if (bus.lsu_req_ready === 1'b1 && bus.ifu_req_ready === 1'b0) got_owner[t] = 1;
            else if (bus.ifu_req_ready === 1'b1 && bus.lsu_req_ready === 1'b0) got_owner[t] = 0;
            else got_owner[t] = 2;
            @(negedge clk);
            if (bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) bad_ready = 1'b1;
            if (got_owner[t] == 1) begin lrem--; if (lrem == 0) bus.lsu_req_valid = 1'b0; end
            else if (got_owner[t] == 0) begin irem--; if (irem == 0) bus.ifu_req_valid = 1'b0; end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            if (bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) bad_ready = 1'b1;
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'(t);
            @(negedge clk);
            if (bus.ifu_req_ready !== 1'b0 || bus.lsu_req_ready !== 1'b0) bad_ready = 1'b1;
            bus.mem_rsp_valid = 1'b0;
            @(negedge clk);
        end
        clear_inputs();
        for (int t = 0; t < 6; t++) begin
            checks++; if (got_owner[t] != int'(exp_lsu[t])) begin
                failures++; $display("FAIL arb_grant%0d got=%0d exp=%0d (1=LSU)", t, got_owner[t], exp_lsu[t]); end
        end
        checks++; if (bad_ready) begin
            failures++; $display("FAIL arb_ready_busy got=1 exp=0"); end
    endtask

    task automatic test_stall();
        obs_t o;
        run_txn(1'b1, 32'h8000_2004, 1'b0, 32'hA5A5_5A5A, 4'b1111, 5, 2, 32'h0BAD_F00D, o);
        checks++; if (!o.issue_stable || o.addr !== 32'h8000_2004 || o.wdata !== 32'hA5A5_5A5A) begin
            failures++; $display("FAIL stall_hold got=%b/%h/%h exp=1/80002004/a5a55a5a", o.issue_stable, o.addr, o.wdata); end
        checks++; if (o.wait_entry != 7 || o.timed_out || o.lat != 10) begin
            failures++; $display("FAIL stall_latency got=%0d/%0d exp=7/10", o.wait_entry, o.lat); end
        checks++; if (o.lsu_rsp !== 1'b1 || o.rdata !== 32'h0BAD_F00D || o.err !== 1'b0) begin
            failures++; $display("FAIL stall_rsp got=%b/%h/%b exp=1/0badf00d/0", o.lsu_rsp, o.rdata, o.err); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(1'b0, 32'h8000_0040, 1'b0, '0, '0, 0, -1, '0, o);
        checks++; if (o.timed_out || (o.lat - o.wait_entry) != 16) begin
            failures++; $display("FAIL timeout_delay got=%0d exp=16", o.lat - o.wait_entry); end
        checks++; if (o.ifu_rsp !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.extra_pulse !== 1'b0) begin
            failures++; $display("FAIL timeout_rsp got=%b/%b/%h/%b exp=1/1/0/0", o.ifu_rsp, o.err, o.rdata, o.extra_pulse); end
        run_txn(1'b0, 32'h8000_0044, 1'b0, '0, '0, 0, 1, 32'h0000_0013, o);
        checks++; if (o.ifu_rdy !== 1'b1 || o.lat != 4 || o.rdata !== 32'h0000_0013 || o.err !== 1'b0) begin
            failures++; $display("FAIL timeout_next got=%b/%0d/%h/%b exp=1/4/13/0", o.ifu_rdy, o.lat, o.rdata, o.err); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int ifu0, lsu0;
        bit stray = 1'b0;
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0080;
        @(negedge clk);
        bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        ifu0 = ifu_pulses; lsu0 = lsu_pulses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.ifu_rsp_valid !== 1'b0 || bus.lsu_rsp_valid !== 1'b0 ||
                      bus.ifu_req_ready !== 1'b0 || bus.rsp_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle got=%b%b%b%b%b exp=00000", bus.mem_req_valid, bus.ifu_rsp_valid,
                                 bus.lsu_rsp_valid, bus.ifu_req_ready, bus.rsp_err); end
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h1111_1111;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
        repeat (4) begin
            if (bus.mem_req_valid !== 1'b0) stray = 1'b1;
            @(negedge clk);
        end
        checks++; if (stray || ifu_pulses != ifu0 || lsu_pulses != lsu0 || bus.rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL rstmid_drop got=%b/%0d/%0d/%h exp=0/0/0/0", stray, ifu_pulses - ifu0,
                                 lsu_pulses - lsu0, bus.rsp_rdata); end
        run_txn(1'b0, 32'h8000_0084, 1'b0, '0, '0, 0, 0, 32'h2222_2222, o);
        checks++; if (o.lat != 3 || o.ifu_rsp !== 1'b1 || o.rdata !== 32'h2222_2222) begin
            failures++; $display("FAIL rstmid_recover got=%0d/%b/%h exp=3/1/22222222", o.lat, o.ifu_rsp, o.rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_arbitration();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
